mem_access_unit: RTL and testbench

- Load/store initiator between the CPU datapath and the byte-wide data memory port.
- Takes one load or store request at a time: byte, halfword or word, signed or unsigned.
- Sequences it as consecutive single-byte memory cycles in big-endian order: lowest address holds the most significant byte.
- Returns a sign- or zero-extended load result, or a store completion, through a one-cycle response pulse.

---
 rtl/mau_pkg.sv | 36 +++
 rtl/mem_access_unit_if.sv | 43 ++++
 rtl/mau_byte_pack.sv | 53 +++++
 rtl/mem_access_unit.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mau_pkg.sv
// ============================================================================
// Module      : mau_pkg
// Description : Shared encodings, FSM state type and helpers for the
//               mem_access_unit load/store initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mau_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // Request sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } mau_state_e;

    // Number of memory byte cycles for a given size (0 for the reserved code)
    function automatic logic [2:0] bytes_of_size(input logic [1:0] size);
        case (size)
            SIZE_BYTE: bytes_of_size = 3'd1;
            SIZE_HALF: bytes_of_size = 3'd2;
            SIZE_WORD: bytes_of_size = 3'd4;
            default:   bytes_of_size = 3'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module      : mem_access_unit_if
// Description : Request/response handshake and byte-wide memory port bundle
//               of the mem_access_unit. The unit connects through the slave
//               modport; the CPU/memory side uses the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_address;
    logic [31:0]       req_data_i;
    logic              resp_valid;
    logic [31:0]       resp_data_o;
    logic              resp_misalign;
    logic              mem_en_write;
    logic [ADDR_W-1:0] mem_address;
    logic [7:0]        mem_data_o;
    logic [7:0]        mem_data_i;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_address,
               req_data_i, mem_data_i,
        output req_ready, resp_valid, resp_data_o, resp_misalign,
               mem_en_write, mem_address, mem_data_o
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_address,
               req_data_i, mem_data_i,
        input  req_ready, resp_valid, resp_data_o, resp_misalign,
               mem_en_write, mem_address, mem_data_o
    );
endinterface

`default_nettype wire

// File: rtl/mau_byte_pack.sv
// ============================================================================
// Module      : mau_byte_pack
// Description : Combinational byte lane logic. Picks the big-endian store
//               byte for a given byte index, and sign/zero-extends the
//               assembled load accumulator to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mau_byte_pack
    import mau_pkg::*;
(
    input  wire logic [31:0] store_data,
    input  wire logic [1:0]  size,
    input  wire logic [1:0]  idx,
    input  wire logic [31:0] acc,
    input  wire logic        load_signed,
    output logic      [7:0]  store_byte,
    output logic      [31:0] load_result
);

    // Byte 0 is the most significant byte of the right-aligned operand
    always_comb begin
        store_byte  = 8'h00;
        load_result = 32'h0;
        case (size)
            SIZE_BYTE: begin
                store_byte  = store_data[7:0];
                load_result = {{24{load_signed & acc[7]}}, acc[7:0]};
            end
            SIZE_HALF: begin
                store_byte  = idx[0] ? store_data[7:0] : store_data[15:8];
                load_result = {{16{load_signed & acc[15]}}, acc[15:0]};
            end
            SIZE_WORD: begin
                case (idx)
                    2'd0:    store_byte = store_data[31:24];
                    2'd1:    store_byte = store_data[23:16];
                    2'd2:    store_byte = store_data[15:8];
                    default: store_byte = store_data[7:0];
                endcase
                load_result = acc;
            end
            default: begin
                store_byte  = 8'h00;
                load_result = 32'h0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store initiator. Accepts one byte/half/word request at a
//               time and sequences it as big-endian single-byte memory
//               cycles, then returns a one-cycle response pulse.
//               Optional build macro: MAU_MISALIGN_CHECK_EN - when defined,
//               misaligned halfword/word requests are rejected with
//               resp_misalign instead of being performed byte by byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 32
)(
    input  wire logic          clk,
    input  wire logic          rst_n,
    mem_access_unit_if.slave   bus
);

    mau_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       acc_q, acc_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              resp_misalign_q, resp_misalign_d;
    logic              mem_en_write_q, mem_en_write_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [7:0]        mem_data_q, mem_data_d;

    logic              w_accept;
    logic              w_err;
    logic              w_last;
    logic [31:0]       w_acc_shift;
    logic [31:0]       w_pack_data;
    logic [1:0]        w_pack_size;
    logic [1:0]        w_pack_idx;
    logic [7:0]        w_store_byte;
    logic [31:0]       w_load_result;

    assign w_accept    = (state_q == IDLE) && bus.req_valid;
    assign w_acc_shift = {acc_q[23:0], bus.mem_data_i};
    assign w_last      = (k_q == 2'(bytes_of_size(size_q) - 3'd1));

    // Requests that are answered immediately without touching memory
`ifdef MAU_MISALIGN_CHECK_EN
    assign w_err = (bus.req_size == SIZE_RSVD)
                 || ((bus.req_size == SIZE_HALF) && bus.req_address[0])
                 || ((bus.req_size == SIZE_WORD) && (bus.req_address[1:0] != 2'b00));
`else
    assign w_err = (bus.req_size == SIZE_RSVD);
`endif

    // Byte lane select looks one cycle ahead: byte 0 on accept, byte k+1 in XFER
    assign w_pack_data = w_accept ? bus.req_data_i : data_q;
    assign w_pack_size = w_accept ? bus.req_size   : size_q;
    assign w_pack_idx  = w_accept ? 2'd0           : k_q + 2'd1;

    mau_byte_pack u_byte_pack (
        .store_data  (w_pack_data),
        .size        (w_pack_size),
        .idx         (w_pack_idx),
        .acc         (w_acc_shift),
        .load_signed (signed_q),
        .store_byte  (w_store_byte),
        .load_result (w_load_result)
    );

    // Next-state and registered-output computation for the request sequencer
    always_comb begin
        state_d         = state_q;
        write_d         = write_q;
        size_d          = size_q;
        signed_d        = signed_q;
        data_d          = data_q;
        k_d             = k_q;
        acc_d           = acc_q;
        resp_valid_d    = 1'b0;
        resp_data_d     = 32'h0;
        resp_misalign_d = 1'b0;
        mem_en_write_d  = 1'b0;
        mem_address_d   = mem_address_q;
        mem_data_d      = mem_data_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    data_d   = bus.req_data_i;
                    k_d      = 2'd0;
                    acc_d    = 32'h0;
                    if (w_err) begin
                        state_d         = RESP;
                        resp_valid_d    = 1'b1;
                        resp_misalign_d = 1'b1;
                    end else begin
                        state_d        = XFER;
                        mem_en_write_d = bus.req_write;
                        mem_address_d  = bus.req_address;
                        if (bus.req_write) begin
                            mem_data_d = w_store_byte;
                        end
                    end
                end
            end
            XFER: begin
                acc_d = w_acc_shift;
                k_d   = k_q + 2'd1;
                if (w_last) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = write_q ? 32'h0 : w_load_result;
                end else begin
                    mem_en_write_d = write_q;
                    mem_address_d  = mem_address_q + ADDR_W'(1);
                    if (write_q) begin
                        mem_data_d = w_store_byte;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            write_q         <= 1'b0;
            size_q          <= SIZE_BYTE;
            signed_q        <= 1'b0;
            data_q          <= 32'h0;
            k_q             <= 2'd0;
            acc_q           <= 32'h0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= 32'h0;
            resp_misalign_q <= 1'b0;
            mem_en_write_q  <= 1'b0;
            mem_address_q   <= '0;
            mem_data_q      <= 8'h00;
        end else begin
            state_q         <= state_d;
            write_q         <= write_d;
            size_q          <= size_d;
            signed_q        <= signed_d;
            data_q          <= data_d;
            k_q             <= k_d;
            acc_q           <= acc_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_misalign_q <= resp_misalign_d;
            mem_en_write_q  <= mem_en_write_d;
            mem_address_q   <= mem_address_d;
            mem_data_q      <= mem_data_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data_o   = resp_data_q;
    assign bus.resp_misalign = resp_misalign_q;
    assign bus.mem_en_write  = mem_en_write_q;
    assign bus.mem_address   = mem_address_q;
    assign bus.mem_data_o    = mem_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. Directed cases plus
//               randomized requests compared against a byte-array reference
//               memory model. Honours MAU_MISALIGN_CHECK_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

`ifdef MAU_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory: combinational read, write sampled on the rising edge
    assign bus.mem_data_i = mem[bus.mem_address[7:0]];
    always @(posedge clk) begin
        if (bus.mem_en_write) mem[bus.mem_address[7:0]] <= bus.mem_data_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [1:0] sz, input logic [31:0] addr);
        return (sz == 2'b11) ||
               (CHK && (((sz == 2'b01) && addr[0]) || ((sz == 2'b10) && (addr[1:0] != 2'b00))));
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // One complete request with cycle-accurate checks; returns observed resp data
    task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] got);
        int          n;
        bit          err;
        logic [31:0] expv;
        logic [7:0]  sb [4];
        err  = is_err(sz, addr);
        n    = nbytes(sz);
        expv = 32'h0;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                sb[i] = 8'((data >> (8 * (n - 1 - i))) & 32'hFF);
                if (wr) ref_mem[8'(addr + 32'(i))] = sb[i];
                else    expv = (expv << 8) | 32'(ref_mem[8'(addr + 32'(i))]);
            end
            if (!wr && sg && n < 4 && expv[8*n-1]) expv = expv | ~((32'h1 << (8 * n)) - 32'h1);
        end

        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_size    = sz;
        bus.req_signed  = sg;
        bus.req_address = addr;
        bus.req_data_i  = data;
        check("ready_before", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid   = 1'b0;
        bus.req_data_i  = $urandom;
        bus.req_address = $urandom;
        if (err) begin
            check("err_valid", 32'(bus.resp_valid), 32'h1);
            check("err_flag", 32'(bus.resp_misalign), 32'h1);
            check("err_data", bus.resp_data_o, 32'h0);
            check("err_nowrite", 32'(bus.mem_en_write), 32'h0);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (i > 0) @(negedge clk);
                check("xfer_en", 32'(bus.mem_en_write), 32'(wr));
                check("xfer_addr", bus.mem_address, addr + 32'(i));
                check("xfer_novalid", 32'(bus.resp_valid), 32'h0);
                if (wr) check("xfer_wdata", 32'(bus.mem_data_o), 32'(sb[i]));
            end
            @(negedge clk);
            check("resp_valid", 32'(bus.resp_valid), 32'h1);
            check("resp_flag", 32'(bus.resp_misalign), 32'h0);
            check("resp_data", bus.resp_data_o, expv);
            check("resp_nowrite", 32'(bus.mem_en_write), 32'h0);
        end
        got = bus.resp_data_o;
        @(negedge clk);
        check("post_valid", 32'(bus.resp_valid), 32'h0);
        check("post_ready", 32'(bus.req_ready), 32'h1);
    endtask

    // Hold req_valid high and check the accept cadence of n+2 cycles
    task automatic b2b(input logic [1:0] sz, input logic [31:0] addr, input int reps);
        int n;
        int t;
        n = nbytes(sz);
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b0;
        bus.req_size    = sz;
        bus.req_signed  = 1'b0;
        bus.req_address = addr;
        for (int c = 0; c < reps * (n + 2); c++) begin
            check("b2b_ready", 32'(bus.req_ready), 32'((c % (n + 2)) == 0));
            check("b2b_resp", 32'(bus.resp_valid), 32'((c % (n + 2)) == n + 1));
            if (c != reps * (n + 2) - 1) @(negedge clk);
        end
        bus.req_valid = 1'b0;
        t = 0;
        while (!bus.req_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("b2b_drain", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
    endtask

    logic [31:0] got;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_size    = 2'b00;
        bus.req_signed  = 1'b0;
        bus.req_address = 32'h0;
        bus.req_data_i  = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'h1);
        check("rst_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_data", bus.resp_data_o, 32'h0);
        check("rst_flag", 32'(bus.resp_misalign), 32'h0);
        check("rst_en", 32'(bus.mem_en_write), 32'h0);
        check("rst_addr", bus.mem_address, 32'h0);
        check("rst_wdata", 32'(bus.mem_data_o), 32'h0);
        rst_n = 1'b1;

        // Fill the whole memory through the unit with word stores
        for (int a = 0; a < 64; a++) do_req(1'b1, 2'b10, 1'b0, 32'(a * 4), $urandom, got);

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80123456, got);
        do_req(1'b1, 2'b00, 1'b0, 32'h14, 32'h00000000, got);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got); check("lw_10", got, 32'h80123456);
        do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, got); check("lb_10", got, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, got); check("lbu_10", got, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, got); check("lh_12", got, 32'h00003456);
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, got); check("lh_10", got, 32'hFFFF8012);
        do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, got); check("lw_11", got, CHK ? 32'h0 : 32'h12345600);
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, got);
        do_req(1'b1, 2'b01, 1'b0, 32'h24, 32'h0000CAFE, got);
        do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, got);
        do_req(1'b1, 2'b11, 1'b0, 32'h40, 32'h12345678, got);
        do_req(1'b0, 2'b10, 1'b1, 32'hFFFFFFFF, 32'h0, got);

        // Reset during a word store: only the first byte lands in memory
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
        bus.req_address = 32'h30; bus.req_data_i = 32'h11223344;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rst_mid_en", 32'(bus.mem_en_write), 32'h1);
        check("rst_mid_wdata", 32'(bus.mem_data_o), 32'h11);
        ref_mem[8'h30] = 8'h11;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 32'(bus.req_ready), 32'h1);
        check("rst_mid_nowrite", 32'(bus.mem_en_write), 32'h0);
        check("rst_mid_novalid", 32'(bus.resp_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_after_novalid", 32'(bus.resp_valid), 32'h0);

        b2b(2'b00, 32'h10, 4);
        b2b(2'b10, 32'h10, 3);

        for (int r = 0; r < 60; r++) begin
            do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                   ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom,
                   $urandom, got);
        end

        begin
            int diff;
            diff = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
            check("mem_contents_diff", 32'(diff), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
